// File: rtl/sine_nco_if.sv
// Control and LUT bus for sine_nco: enable, sync, frequency handshake, LUT address/data, sample output.
interface sine_nco_if #(
   parameter int PHASE_W = 24
);
   logic               en;
   logic               sync_clr;
   logic [PHASE_W-1:0] freq_word;
   logic               freq_valid;
   logic               freq_ready;
   logic [7:0]         lut_addr;
   logic [7:0]         lut_data;
   logic [8:0]         sample_out;
   logic               sample_valid;

   modport master (
      output en, sync_clr, freq_word, freq_valid, lut_data,
      input  freq_ready, lut_addr, sample_out, sample_valid
   );

   modport slave (
      input  en, sync_clr, freq_word, freq_valid, lut_data,
      output freq_ready, lut_addr, sample_out, sample_valid
   );
endinterface

// File: rtl/sine_nco.sv
// Phase-accumulator NCO folding phase into a quarter-wave LUT; 1-cycle sample latency, freq_ready low while a word is pending.
// SINE_UNSIGNED_OUT_EN selects offset-binary output (256 + signed value) instead of two's complement.
module sine_nco #(
   parameter int                 PHASE_W      = 24,
   parameter logic [PHASE_W-1:0] DEFAULT_FREQ = '0
) (
   input logic        clk,
   input logic        rst_n,
   sine_nco_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, RUN, PENDING} state_t;

`ifdef SINE_UNSIGNED_OUT_EN
   localparam logic [8:0] SAMPLE_RST = 9'd256;
`else
   localparam logic [8:0] SAMPLE_RST = 9'd0;
`endif

   state_t             state;
   logic [PHASE_W-1:0] phase_acc;
   logic [PHASE_W-1:0] freq_reg;
   logic [PHASE_W-1:0] pending_reg;
   logic               freq_ready_q;
   logic [8:0]         sample_q;
   logic               sample_valid_q;

   logic [PHASE_W:0]   sum;
   logic               wrap;
   logic [1:0]         quad;
   logic [7:0]         idx;
   logic [8:0]         mag;
   logic [8:0]         sample_nxt;
   logic               xfer;

   assign sum  = {1'b0, phase_acc} + {1'b0, freq_reg};
   assign wrap = sum[PHASE_W];
   assign quad = phase_acc[PHASE_W-1:PHASE_W-2];
   assign idx  = phase_acc[PHASE_W-3:PHASE_W-10];
   assign xfer = bus.freq_valid & freq_ready_q;
   assign mag  = {1'b0, bus.lut_data};

   // Odd quadrants run the quarter wave backwards; the upper half is negated.
`ifdef SINE_UNSIGNED_OUT_EN
   assign sample_nxt = quad[1] ? (9'd256 - mag) : (9'd256 + mag);
`else
   assign sample_nxt = quad[1] ? (9'd0 - mag) : mag;
`endif

   assign bus.lut_addr     = quad[0] ? (8'd255 - idx) : idx;
   assign bus.freq_ready   = freq_ready_q;
   assign bus.sample_out   = sample_q;
   assign bus.sample_valid = sample_valid_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         phase_acc      <= '0;
         freq_reg       <= DEFAULT_FREQ;
         pending_reg    <= '0;
         freq_ready_q   <= 1'b1;
         sample_q       <= SAMPLE_RST;
         sample_valid_q <= 1'b0;
      end else begin
         if (bus.sync_clr)
            phase_acc <= '0;
         else if (bus.en && state != IDLE)
            phase_acc <= sum[PHASE_W-1:0];

         if (bus.en)
            sample_q <= sample_nxt;
         sample_valid_q <= bus.en;

         case (state)
            IDLE: begin
               if (xfer)
                  freq_reg <= bus.freq_word;
               if (bus.en)
                  state <= RUN;
            end
            RUN: begin
               if (xfer && bus.en) begin
                  pending_reg  <= bus.freq_word;
                  freq_ready_q <= 1'b0;
                  state        <= PENDING;
               end else if (xfer) begin
                  freq_reg <= bus.freq_word;
                  state    <= IDLE;
               end else if (!bus.en) begin
                  state <= IDLE;
               end
            end
            PENDING: begin
               // Swap on wrap keeps the waveform phase-continuous.
               if (!bus.en) begin
                  freq_reg     <= pending_reg;
                  freq_ready_q <= 1'b1;
                  state        <= IDLE;
               end else if (bus.sync_clr || wrap) begin
                  freq_reg     <= pending_reg;
                  freq_ready_q <= 1'b1;
                  state        <= RUN;
               end
            end
            default: begin
               freq_ready_q <= 1'b1;
               state        <= IDLE;
            end
         endcase
      end
   end
endmodule
